// File: rtl/sicaklik_pkg.sv
// Shared types and width helpers for the temperature monitor.
package sicaklik_pkg;

    typedef enum logic [1:0] {NORMAL, SAYIM, ALARM} durum_e;

    localparam int unsigned KELVIN_OFSET = 273;

    function automatic int unsigned toplam_genislik(input int unsigned veri_w,
                                                    input int unsigned pencere_log2);
        return veri_w + pencere_log2;
    endfunction

    function automatic int unsigned cikis_genislik(input int unsigned veri_w,
                                                   input int unsigned kelvin);
        return veri_w + 2 * kelvin;
    endfunction

endpackage

// File: rtl/kayan_ortalama.sv
// Sliding-window sum over 2^PENCERE_LOG2 samples; empty slots count as zero.
module kayan_ortalama
    import sicaklik_pkg::*;
#(
    parameter int unsigned VERI_W       = 7,
    parameter int unsigned PENCERE_LOG2 = 2
) (
    input  logic              saat,
    input  logic              reset_n,
    input  logic              giris_gecerli,
    input  logic [VERI_W-1:0] sicaklik,
    output logic [VERI_W-1:0] ortalama,
    output logic              dolu
);

    localparam int unsigned N  = 1 << PENCERE_LOG2;
    localparam int unsigned TW = toplam_genislik(VERI_W, PENCERE_LOG2);
    localparam int unsigned DW = PENCERE_LOG2 + 1;
    localparam logic [DW-1:0] N_SAYI = DW'(N);

    logic [VERI_W-1:0]       tampon_q [N];
    logic [TW-1:0]           toplam_q, toplam_d;
    logic [PENCERE_LOG2-1:0] yaz_q;
    logic [DW-1:0]           doluluk_q, doluluk_d;

    // Both outputs describe the window as it stands after accepting the current sample.
    always_comb begin
        toplam_d  = toplam_q + TW'(sicaklik) - TW'(tampon_q[yaz_q]);
        doluluk_d = (doluluk_q == N_SAYI) ? doluluk_q : doluluk_q + DW'(1);
        ortalama  = toplam_d[TW-1:PENCERE_LOG2];
        dolu      = (doluluk_d == N_SAYI);
    end

    always_ff @(posedge saat or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                tampon_q[i] <= '0;
            end
            toplam_q  <= '0;
            yaz_q     <= '0;
            doluluk_q <= '0;
        end else if (giris_gecerli) begin
            tampon_q[yaz_q] <= sicaklik;
            toplam_q        <= toplam_d;
            yaz_q           <= yaz_q + PENCERE_LOG2'(1);
            doluluk_q       <= doluluk_d;
        end
    end

endmodule

// File: rtl/sicaklik_izleyici.sv
// Temperature monitor: moving average with a debounced hysteresis alarm and optional Kelvin output.
module sicaklik_izleyici
    import sicaklik_pkg::*;
#(
    parameter int unsigned VERI_W       = 7,
    parameter int unsigned PENCERE_LOG2 = 2,
    parameter int unsigned ALARM_SAYAC  = 1,
    parameter int unsigned KELVIN       = 0
) (
    input  logic                                          saat,
    input  logic                                          reset_n,
    input  logic                                          giris_gecerli,
    input  logic [VERI_W-1:0]                             sicaklik,
    input  logic [VERI_W-1:0]                             esik_ust,
    input  logic [VERI_W-1:0]                             esik_alt,
    output logic [cikis_genislik(VERI_W, KELVIN)-1:0]     ortalama_sicaklik,
    output logic                                          cikis_gecerli,
    output logic                                          pencere_dolu,
    output logic                                          alarm_cal
);

    localparam int unsigned OW      = cikis_genislik(VERI_W, KELVIN);
    localparam int unsigned SAYAC_W = (ALARM_SAYAC > 1) ? $clog2(ALARM_SAYAC + 1) : 1;
    localparam logic [SAYAC_W-1:0] HEDEF = SAYAC_W'(ALARM_SAYAC);
    localparam logic [OW-1:0]      OFSET = (KELVIN != 0) ? OW'(KELVIN_OFSET) : '0;

    logic [VERI_W-1:0]  ortalama;
    logic               dolu;
    logic [VERI_W-1:0]  esik_temiz;
    logic               ust_asildi, temizle;
    logic [OW-1:0]      cikis_deger;
    logic [SAYAC_W-1:0] sayac_q, sayac_art;
    durum_e             durum_q;

    kayan_ortalama #(
        .VERI_W       (VERI_W),
        .PENCERE_LOG2 (PENCERE_LOG2)
    ) u_kayan_ortalama (
        .saat          (saat),
        .reset_n       (reset_n),
        .giris_gecerli (giris_gecerli),
        .sicaklik      (sicaklik),
        .ortalama      (ortalama),
        .dolu          (dolu)
    );

    // Thresholds always compare against the Celsius average; a crossed pair clamps to esik_ust.
    always_comb begin
        esik_temiz  = (esik_alt < esik_ust) ? esik_alt : esik_ust;
        ust_asildi  = (ortalama >= esik_ust);
        temizle     = (ortalama < esik_temiz);
        sayac_art   = sayac_q + SAYAC_W'(1);
        cikis_deger = OW'(ortalama) + OFSET;
    end

    always_ff @(posedge saat or negedge reset_n) begin
        if (!reset_n) begin
            durum_q           <= NORMAL;
            sayac_q           <= '0;
            ortalama_sicaklik <= '0;
            cikis_gecerli     <= 1'b0;
            pencere_dolu      <= 1'b0;
            alarm_cal         <= 1'b0;
        end else begin
            cikis_gecerli <= giris_gecerli;
            if (giris_gecerli) begin
                ortalama_sicaklik <= cikis_deger;
                pencere_dolu      <= dolu;
                // Alarm logic only runs once the window holds N real samples.
                if (dolu) begin
                    case (durum_q)
                        NORMAL: begin
                            if (ust_asildi) begin
                                if (ALARM_SAYAC == 1) begin
                                    durum_q   <= ALARM;
                                    alarm_cal <= 1'b1;
                                end else begin
                                    durum_q <= SAYIM;
                                    sayac_q <= SAYAC_W'(1);
                                end
                            end
                        end
                        SAYIM: begin
                            if (!ust_asildi) begin
                                durum_q <= NORMAL;
                                sayac_q <= '0;
                            end else if (sayac_art == HEDEF) begin
                                durum_q   <= ALARM;
                                sayac_q   <= '0;
                                alarm_cal <= 1'b1;
                            end else begin
                                sayac_q <= sayac_art;
                            end
                        end
                        ALARM: begin
                            if (temizle) begin
                                durum_q   <= NORMAL;
                                alarm_cal <= 1'b0;
                            end
                        end
                        default: begin
                            durum_q   <= NORMAL;
                            sayac_q   <= '0;
                            alarm_cal <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sicaklik_izleyici.sv
// Directed bench for sicaklik_izleyici across default, debounce, Kelvin and 8-deep configurations.
module tb_sicaklik_izleyici;

    logic       saat;
    logic       reset_n;
    logic       giris_gecerli;
    logic [6:0] sicaklik, esik_ust, esik_alt;

    logic [6:0] d_ort;  logic d_gec, d_dolu, d_alarm;
    logic [6:0] s_ort;  logic s_gec, s_dolu, s_alarm;
    logic [8:0] k_ort;  logic k_gec, k_dolu, k_alarm;
    logic [6:0] g_ort;  logic g_gec, g_dolu, g_alarm;

    int toplam = 0;
    int hata   = 0;

    int m_tampon [8];
    int m_yaz, m_toplam, beklenen, bosluk, v;

    sicaklik_izleyici u_dut (
        .saat (saat), .reset_n (reset_n), .giris_gecerli (giris_gecerli),
        .sicaklik (sicaklik), .esik_ust (esik_ust), .esik_alt (esik_alt),
        .ortalama_sicaklik (d_ort), .cikis_gecerli (d_gec),
        .pencere_dolu (d_dolu), .alarm_cal (d_alarm)
    );

    sicaklik_izleyici #(.ALARM_SAYAC (3)) u_say (
        .saat (saat), .reset_n (reset_n), .giris_gecerli (giris_gecerli),
        .sicaklik (sicaklik), .esik_ust (esik_ust), .esik_alt (esik_alt),
        .ortalama_sicaklik (s_ort), .cikis_gecerli (s_gec),
        .pencere_dolu (s_dolu), .alarm_cal (s_alarm)
    );

    sicaklik_izleyici #(.KELVIN (1)) u_kel (
        .saat (saat), .reset_n (reset_n), .giris_gecerli (giris_gecerli),
        .sicaklik (sicaklik), .esik_ust (esik_ust), .esik_alt (esik_alt),
        .ortalama_sicaklik (k_ort), .cikis_gecerli (k_gec),
        .pencere_dolu (k_dolu), .alarm_cal (k_alarm)
    );

    sicaklik_izleyici #(.PENCERE_LOG2 (3)) u_gen (
        .saat (saat), .reset_n (reset_n), .giris_gecerli (giris_gecerli),
        .sicaklik (sicaklik), .esik_ust (esik_ust), .esik_alt (esik_alt),
        .ortalama_sicaklik (g_ort), .cikis_gecerli (g_gec),
        .pencere_dolu (g_dolu), .alarm_cal (g_alarm)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen_deger);
        toplam++;
        if (gozlenen !== beklenen_deger) begin
            hata++;
            $display("FAIL %s: observed %0d, expected %0d", etiket, gozlenen, beklenen_deger);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs updated.
    task automatic ornek(input logic [6:0] deger);
        sicaklik      = deger;
        giris_gecerli = 1'b1;
        @(negedge saat);
        giris_gecerli = 1'b0;
    endtask

    task automatic sifirla();
        giris_gecerli = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge saat);
        reset_n = 1'b1;
        @(negedge saat);
    endtask

    initial begin
        reset_n       = 1'b1;
        giris_gecerli = 1'b0;
        sicaklik      = '0;
        esik_ust      = 7'd50;
        esik_alt      = 7'd40;
        #1 reset_n = 1'b0;
        @(negedge saat);
        kontrol("reset_ort",   d_ort,   0);
        kontrol("reset_gec",   d_gec,   0);
        kontrol("reset_dolu",  d_dolu,  0);
        kontrol("reset_alarm", d_alarm, 0);
        kontrol("reset_kelvin_ort", k_ort, 0);
        reset_n = 1'b1;
        @(negedge saat);

        // Fill with 100s: diluted averages, alarm only once full.
        ornek(7'd100);
        kontrol("t1_ort1", d_ort, 25);  kontrol("t1_dolu1", d_dolu, 0);
        kontrol("t1_alarm1", d_alarm, 0); kontrol("t1_gec1", d_gec, 1);
        ornek(7'd100);
        kontrol("t1_ort2", d_ort, 50);  kontrol("t1_alarm2", d_alarm, 0);
        ornek(7'd100);
        kontrol("t1_ort3", d_ort, 75);  kontrol("t1_dolu3", d_dolu, 0);
        kontrol("t1_alarm3", d_alarm, 0);
        ornek(7'd100);
        kontrol("t1_ort4", d_ort, 100); kontrol("t1_dolu4", d_dolu, 1);
        kontrol("t1_alarm4", d_alarm, 1);

        // Hysteresis: alarm holds until strictly below the clear threshold.
        ornek(7'd40); kontrol("t2_ort85", d_ort, 85); kontrol("t2_alarm85", d_alarm, 1);
        ornek(7'd40); kontrol("t2_ort70", d_ort, 70); kontrol("t2_alarm70", d_alarm, 1);
        ornek(7'd40); kontrol("t2_ort55", d_ort, 55); kontrol("t2_alarm55", d_alarm, 1);
        ornek(7'd40); kontrol("t2_ort40", d_ort, 40); kontrol("t2_alarm40", d_alarm, 1);
        ornek(7'd30); kontrol("t2_ort37", d_ort, 37); kontrol("t2_alarm37", d_alarm, 0);
        kontrol("t2_dolu", d_dolu, 1);

        // Debounce of 3 after a prefill that does not count.
        sifirla();
        esik_ust = 7'd127; esik_alt = 7'd0;
        repeat (4) ornek(7'd60);
        kontrol("t3_prefill_alarm", s_alarm, 0);
        esik_ust = 7'd50; esik_alt = 7'd40;
        ornek(7'd60); kontrol("t3_say1", s_alarm, 0);
        ornek(7'd60); kontrol("t3_say2", s_alarm, 0);
        ornek(7'd60); kontrol("t3_say3", s_alarm, 1);

        sifirla();
        esik_ust = 7'd127; esik_alt = 7'd0;
        repeat (4) ornek(7'd60);
        esik_ust = 7'd52;
        ornek(7'd60); kontrol("t3b_a1", s_alarm, 0);
        ornek(7'd60); kontrol("t3b_a2", s_alarm, 0);
        ornek(7'd20); kontrol("t3b_ort", s_ort, 50); kontrol("t3b_dusus", s_alarm, 0);
        esik_ust = 7'd40; esik_alt = 7'd30;
        ornek(7'd60); kontrol("t3b_yeniden1", s_alarm, 0);
        ornek(7'd60); kontrol("t3b_yeniden2", s_alarm, 0);
        ornek(7'd60); kontrol("t3b_yeniden3", s_alarm, 1);

        // Kelvin offset; thresholds still Celsius.
        sifirla();
        esik_ust = 7'd25; esik_alt = 7'd20;
        ornek(7'd20); kontrol("t4_k1", k_ort, 278);
        ornek(7'd20); kontrol("t4_k2", k_ort, 283);
        ornek(7'd20); kontrol("t4_k3", k_ort, 288);
        ornek(7'd20); kontrol("t4_k4", k_ort, 293);
        kontrol("t4_dolu", k_dolu, 1); kontrol("t4_alarm", k_alarm, 0);

        // 8-deep window with idle gaps against a reference sum.
        sifirla();
        esik_ust = 7'd127; esik_alt = 7'd0;
        for (int i = 0; i < 8; i++) m_tampon[i] = 0;
        m_yaz = 0; m_toplam = 0;
        for (int k = 0; k < 50; k++) begin
            v = int'($urandom_range(0, 127));
            ornek(7'(v));
            m_toplam = m_toplam + v - m_tampon[m_yaz];
            m_tampon[m_yaz] = v;
            m_yaz = (m_yaz + 1) % 8;
            beklenen = m_toplam >> 3;
            kontrol("t5_ort", g_ort, beklenen);
            kontrol("t5_gec", g_gec, 1);
            if (k == 6) kontrol("t5_dolu7", g_dolu, 0);
            if (k == 7) kontrol("t5_dolu8", g_dolu, 1);
            bosluk = int'($urandom_range(0, 2));
            repeat (bosluk) begin
                @(negedge saat);
                kontrol("t5_tut_ort", g_ort, beklenen);
                kontrol("t5_tut_gec", g_gec, 0);
            end
        end

        // Asynchronous reset between edges while the alarm is active.
        sifirla();
        esik_ust = 7'd50; esik_alt = 7'd40;
        repeat (4) ornek(7'd100);
        kontrol("t6_onceki_alarm", d_alarm, 1);
        #2 reset_n = 1'b0;
        #1;
        kontrol("t6_ort",   d_ort,   0);
        kontrol("t6_gec",   d_gec,   0);
        kontrol("t6_dolu",  d_dolu,  0);
        kontrol("t6_alarm", d_alarm, 0);
        @(negedge saat);
        reset_n = 1'b1;
        @(negedge saat);
        ornek(7'd100); kontrol("t6_ort1", d_ort, 25);
        ornek(7'd100);
        ornek(7'd100); kontrol("t6_ort3", d_ort, 75);
        kontrol("t6_sonra_alarm", d_alarm, 0);
        kontrol("t6_sonra_dolu",  d_dolu,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", toplam, hata);
        $finish;
    end

endmodule

// File: doc/sicaklik_izleyici.md
Name: sicaklik_izleyici

Overview:
- Parametrised temperature monitor: sliding-window moving average over 2^PENCERE_LOG2 samples, with a hysteresis alarm and a debounce counter.
- Samples are accepted only on a valid strobe. The output is optionally offset to Kelvin.
- Sits between the sensor sampler and the alarm/display logic.
- Successor to the fixed 4-sample, fixed-threshold alarm block.

Parameters:
- VERI_W, 7, sample width in bits (unsigned °C). Must be ≥7 when KELVIN=1.
- PENCERE_LOG2, 2, log2 of the window depth N (N = 4 by default). Legal range 1..6.
- ALARM_SAYAC, 1, consecutive over-threshold averages required to raise the alarm. Must be ≥1.
- KELVIN, 0, 1 = add 273 to the reported average.

Ports:
- saat  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- giris_gecerli  in  1  sample-valid strobe.
- sicaklik  in  VERI_W  sample in °C.
- esik_ust  in  VERI_W  alarm-raise threshold.
- esik_alt  in  VERI_W  alarm-clear threshold.
- ortalama_sicaklik  out  VERI_W+2*KELVIN  registered window average, in °C or K.
- cikis_gecerli  out  1  one-cycle pulse when ortalama_sicaklik updates.
- pencere_dolu  out  1  high once N samples have been accepted since reset.
- alarm_cal  out  1  alarm output.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Sample buffer, running sum, write pointer, fill counter and debounce counter all go to 0.
  - FSM goes to NORMAL.
  - All outputs go to 0.
- Sample storage:
  - Circular buffer of N entries, plus a running sum of width VERI_W+PENCERE_LOG2.
  - On a rising edge with giris_gecerli=1: sum ← sum + sicaklik − buf[wp]; buf[wp] ← sicaklik; wp ← wp+1 (wraps modulo N).
  - Empty slots read as 0, so before the window fills the average is diluted (zero-filled), matching the previous generation.
- Average: avg = new_sum >> PENCERE_LOG2, a truncating divide. It is VERI_W bits wide and cannot overflow.
- Outputs: ortalama_sicaklik ← avg (+273 when KELVIN=1), registered in the same edge as the sample. Latency is 1 cycle from the strobe edge to the visible output.
- cikis_gecerli: high for exactly the cycle after each accepted sample, otherwise 0.
- While giris_gecerli=0, every register holds its value.
- Fill tracking: the fill counter saturates at N. pencere_dolu rises in the same edge that accepts sample N, and stays high until reset.
- Threshold comparisons:
  - Always made on the Celsius avg, before any Kelvin offset.
  - Thresholds are sampled at the same edge as the sample.
  - Effective clear threshold = min(esik_alt, esik_ust).
- Alarm evaluation happens only on an accepted sample where the window is full after that sample. Otherwise the FSM holds NORMAL and the debounce counter holds 0.
- FSM transitions (on evaluated samples):
  - NORMAL: avg ≥ esik_ust with ALARM_SAYAC=1 → ALARM. With ALARM_SAYAC>1 → SAYIM, cnt=1. Otherwise stay.
  - SAYIM: avg ≥ esik_ust → cnt+1; when cnt+1 = ALARM_SAYAC → ALARM, cnt=0. avg < esik_ust → NORMAL, cnt=0.
  - ALARM: avg < clear threshold → NORMAL. Otherwise stay, including while avg is between the two thresholds (hysteresis).
- alarm_cal is registered and equals (next state == ALARM). It updates in the same edge as ortalama_sicaklik.
- Reset asserted mid-operation clears everything immediately, including an active alarm. Refill and re-qualification are required afterwards.
- Width rule: ortalama_sicaklik width VERI_W+2 is sufficient for 273 + (2^VERI_W − 1) when VERI_W ≥ 7.

Decomposition:
- Package sicaklik_pkg holds:
  - FSM state enum: NORMAL, SAYIM, ALARM.
  - KELVIN_OFSET = 273.
  - Width helper functions for the sum and output widths.
- One sub-module: kayan_ortalama. It owns the circular buffer, running sum, pointer and fill counter, and outputs avg and dolu.
- The FSM, debounce logic and output registers stay in the top level.

Test Plan:
1. Defaults, esik_ust=50, esik_alt=40. Feed 100, 100, 100, 100. Averages after each sample: 25, 50, 75, 100. pencere_dolu rises with the 4th sample. alarm_cal rises in the same cycle that avg=100 is shown; no alarm on the earlier samples because the window was not full.
2. Hysteresis (full window, alarm active): feed 40 ×4 → avg steps 85, 70, 55, 40. Alarm stays on through 55 and 40 (not < 40). Then feed 30 → avg 37, alarm drops.
3. ALARM_SAYAC=3, window prefilled with 60, esik_ust=50. First three 60-samples → alarm rises on the third. Separately: 60, 60, 20 → FSM returns to NORMAL with cnt=0 and no alarm; the following 60, 60, 60 must count from 1 again.
4. KELVIN=1, feed 20 ×4 → ortalama_sicaklik = 278, 283, 288, 293 (9-bit). Threshold esik_ust=25 is compared against the Celsius value.
5. Strobe gaps: giris_gecerli toggled with idle cycles between samples → outputs hold during gaps, and cikis_gecerli pulses once per sample. PENCERE_LOG2=3: pointer wrap after 8 samples, with the sum equal to a golden model for 50 random samples.
6. Assert reset_n low asynchronously, between edges, while the alarm is high → all outputs 0 immediately. After release, 3 samples give no alarm and pencere_dolu=0.
